glyph_pixel_shifter: RTL and testbench



---
 rtl/glyph_pkg.sv | 25 ++
 rtl/glyph_pixel_shifter_if.sv | 31 +++
 rtl/glyph_row_buffer.sv | 37 +++
 rtl/glyph_pixel_shifter.sv | 140 ++++++++++++++
 tb/tb_glyph_pixel_shifter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/glyph_pkg.sv
// Shared types and defaults for the glyph pixel shifter.
// Row bundles are {r,g,b}, red bitmap in the top bits.
package glyph_pkg;

    typedef enum logic [1:0] {
        S_BLANK  = 2'd0,
        S_ACTIVE = 2'd1,
        S_CLIP   = 2'd2
    } state_t;

    localparam int GLYPH_W_DEF = 12;
    localparam int H_LIMIT_DEF = 636;
    localparam int ROW_W_DEF   = 3 * GLYPH_W_DEF;

    typedef struct packed {
        logic [GLYPH_W_DEF-1:0] r;
        logic [GLYPH_W_DEF-1:0] g;
        logic [GLYPH_W_DEF-1:0] b;
    } glyph_row_t;

    function automatic int row_w(input int w);
        return 3 * w;
    endfunction

endpackage

// File: rtl/glyph_pixel_shifter_if.sv
// Glyph row handshake between the glyph generator and the shifter.
// The master offers one R/G/B row per glyph cell.
interface glyph_pixel_shifter_if
    import glyph_pkg::*;
#(
    parameter int GLYPH_W = GLYPH_W_DEF
);

    logic [GLYPH_W-1:0] row_r;
    logic [GLYPH_W-1:0] row_g;
    logic [GLYPH_W-1:0] row_b;
    logic               row_valid;
    logic               row_ready;

    modport master (
        output row_r,
        output row_g,
        output row_b,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_r,
        input  row_g,
        input  row_b,
        input  row_valid,
        output row_ready
    );

endinterface

// File: rtl/glyph_row_buffer.sv
// Single-entry valid/ready row buffer.
// A pop and a push may happen on the same edge without a bubble.
module glyph_row_buffer
    import glyph_pkg::*;
#(
    parameter int W = row_w(GLYPH_W_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] push_data,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic         pop,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_q;
    logic [W-1:0] data_q;

    assign push_ready = !full_q || pop;
    assign full       = full_q;
    assign data       = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (push_valid && push_ready) begin
            full_q <= 1'b1;
            data_q <= push_data;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/glyph_pixel_shifter.sv
// Serialises buffered glyph rows MSB-first onto registered VGA RGB.
// GLYPH_UNDERRUN_STATS_EN adds clear_stats and a saturating underrun_cnt.
module glyph_pixel_shifter
    import glyph_pkg::*;
#(
    parameter int GLYPH_W  = GLYPH_W_DEF,
    parameter int HCOUNT_W = 11,
    parameter int H_LIMIT  = H_LIMIT_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pix_en,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic                bright,
    glyph_pixel_shifter_if.slave rows,
    output logic                red,
    output logic                green,
    output logic                blue,
    output logic                underrun
`ifdef GLYPH_UNDERRUN_STATS_EN
    ,
    input  logic                clear_stats,
    output logic [CNT_W-1:0]    underrun_cnt
`endif
);

    localparam int CW = $clog2(GLYPH_W);
    localparam int RW = row_w(GLYPH_W);
    localparam logic [HCOUNT_W-1:0] LIMIT = HCOUNT_W'(H_LIMIT);
    localparam logic [CW-1:0] LAST = CW'(GLYPH_W - 1);

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   shifter;
    logic [RW-1:0]   buf_data;
    logic [RW-1:0]   next_row;
    logic [RW-1:0]   row_sel;
    logic            buf_full;
    logic            load;
    logic            clip;
    logic            starve;
    logic [CW-1:0]   idx;
    logic [2:0]      pix;

    glyph_row_buffer #(
        .W (RW)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_data  ({rows.row_r, rows.row_g, rows.row_b}),
        .push_valid (rows.row_valid),
        .push_ready (rows.row_ready),
        .pop        (load),
        .full       (buf_full),
        .data       (buf_data)
    );

    // A load is the tick that shows pixel 0 of a new glyph, so the
    // first bit comes straight from the incoming row.
    always_comb begin
        clip = hcount >= LIMIT;
        load = 1'b0;
        if (pix_en && bright) begin
            case (state)
                S_BLANK:  load = 1'b1;
                S_ACTIVE: load = !clip && (col == '0);
                default:  load = 1'b0;
            endcase
        end
        starve   = load && !buf_full;
        next_row = buf_full ? buf_data : '0;
        row_sel  = load ? next_row : shifter;
        idx      = load ? LAST : LAST - col;
        pix = {
            row_sel[2*GLYPH_W + int'(idx)],
            row_sel[GLYPH_W + int'(idx)],
            row_sel[int'(idx)]
        };
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_BLANK;
            col      <= '0;
            shifter  <= '0;
            red      <= 1'b0;
            green    <= 1'b0;
            blue     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= starve;
            if (load) shifter <= next_row;
            if (pix_en) begin
                case (state)
                    S_BLANK: begin
                        {red, green, blue} <= bright ? pix : 3'b000;
                        if (bright) begin
                            state <= S_ACTIVE;
                            col   <= CW'(1);
                        end
                    end
                    S_ACTIVE: begin
                        if (!bright) begin
                            {red, green, blue} <= 3'b000;
                            state <= S_BLANK;
                        end else if (clip) begin
                            {red, green, blue} <= 3'b000;
                            state <= S_CLIP;
                        end else begin
                            {red, green, blue} <= pix;
                            col <= (col == LAST) ? '0 : col + CW'(1);
                        end
                    end
                    S_CLIP: begin
                        {red, green, blue} <= 3'b000;
                        if (!bright) state <= S_BLANK;
                    end
                    default: begin
                        {red, green, blue} <= 3'b000;
                        state <= S_BLANK;
                    end
                endcase
            end
        end
    end

`ifdef GLYPH_UNDERRUN_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (pix_en && bright && state == S_BLANK && clear_stats) begin
            underrun_cnt <= starve ? CNT_W'(1) : '0;
        end else if (starve && underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_glyph_pixel_shifter.sv
// Directed bench for glyph_pixel_shifter: vector tables per line
// plus hand sequences for slow ticks, mid-glyph reset and stats.
module tb_glyph_pixel_shifter;
    import glyph_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        bright = 1'b0;
    logic [10:0] hcount = '0;
    logic        red;
    logic        green;
    logic        blue;
    logic        underrun;
`ifdef GLYPH_UNDERRUN_STATS_EN
    logic        clear_stats = 1'b0;
    logic [15:0] underrun_cnt;
`endif

    glyph_pixel_shifter_if #(.GLYPH_W(12)) rif ();

    glyph_pixel_shifter #(
        .GLYPH_W  (12),
        .HCOUNT_W (11),
        .H_LIMIT  (636),
        .CNT_W    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_en       (pix_en),
        .hcount       (hcount),
        .bright       (bright),
        .rows         (rif),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .underrun     (underrun)
`ifdef GLYPH_UNDERRUN_STATS_EN
        ,
        .clear_stats  (clear_stats),
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pe;
        logic       br;
        logic [10:0] hc;
        logic       vld;
        glyph_row_t row;
        logic       exp_rdy;
        logic [2:0] exp_rgb;
        logic       exp_und;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    glyph_row_t R0 = '{r: 12'hF00, g: 12'h000, b: 12'h00F};
    glyph_row_t R1 = '{r: 12'hA5A, g: 12'h0F0, b: 12'h000};
    glyph_row_t R2 = '{r: 12'h000, g: 12'h000, b: 12'hC03};
    glyph_row_t R3 = '{r: 12'h000, g: 12'h813, b: 12'h000};
    glyph_row_t R4 = '{r: 12'h3C3, g: 12'h000, b: 12'h111};
    glyph_row_t R5 = '{r: 12'hFFF, g: 12'hAAA, b: 12'h555};
    glyph_row_t R6 = '{r: 12'h800, g: 12'h001, b: 12'h0F0};
    glyph_row_t R7 = '{r: 12'hC30, g: 12'h0C3, b: 12'h30C};
    glyph_row_t R8 = '{r: 12'h111, g: 12'h222, b: 12'h444};
    glyph_row_t R9 = '{r: 12'hFFF, g: 12'h000, b: 12'h000};
    glyph_row_t RZ = '{r: 12'h000, g: 12'h000, b: 12'h000};

    function automatic logic [2:0] bit_of(glyph_row_t r, int p);
        return {r.r[11-p], r.g[11-p], r.b[11-p]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_row(input logic vld, input glyph_row_t r);
        rif.row_valid = vld;
        rif.row_r = r.r;
        rif.row_g = r.g;
        rif.row_b = r.b;
    endtask

    task automatic add(input logic pe, input logic br, input int hc,
                       input logic vld, input glyph_row_t row,
                       input logic rdy, input logic [2:0] rgb,
                       input logic und);
        vec_t v;
        v.pe = pe;
        v.br = br;
        v.hc = 11'(hc);
        v.vld = vld;
        v.row = row;
        v.exp_rdy = rdy;
        v.exp_rgb = rgb;
        v.exp_und = und;
        vq.push_back(v);
    endtask

    task automatic run(input string tag);
        foreach (vq[i]) begin
            pix_en = vq[i].pe;
            bright = vq[i].br;
            hcount = vq[i].hc;
            drive_row(vq[i].vld, vq[i].row);
            #1;
            chk($sformatf("%s%0d_rdy", tag, i), 32'(rif.row_ready),
                32'(vq[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("%s%0d_rgb", tag, i), 32'({red, green, blue}),
                32'(vq[i].exp_rgb));
            chk($sformatf("%s%0d_und", tag, i), 32'(underrun),
                32'(vq[i].exp_und));
        end
        vq.delete();
    endtask

    initial begin
        glyph_row_t line[3];
        glyph_row_t offer;

        drive_row(1'b0, RZ);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_und", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 32'(rif.row_ready), 32'd1);

        // three glyphs back to back
        line[0] = R0;
        line[1] = R1;
        line[2] = R2;
        add(1, 0, 700, 1, R0, 1, 3'b000, 0);
        for (int h = 0; h < 36; h++) begin
            offer = (h == 0) ? R1 : (h <= 12) ? R2 : R3;
            add(1, 1, h, h <= 24, offer, (h % 12) == 0,
                bit_of(line[h/12], h % 12), 0);
        end
        add(1, 0, 36, 0, R3, 0, 3'b000, 0);
        run("b2b");

        // second row withheld, R4 arrives late
        for (int h = 0; h < 36; h++) begin
            logic [2:0] e;
            e = (h < 12) ? bit_of(R3, h) :
                (h < 24) ? 3'b000 : bit_of(R4, h - 24);
            add(1, 1, h, h == 15, R4, !(h >= 16 && h <= 23), e, h == 12);
        end
        add(1, 0, 36, 0, RZ, 1, 3'b000, 0);
        run("starve");

        // clip at H_LIMIT, buffer kept for next line
        add(1, 0, 0, 1, R5, 1, 3'b000, 0);
        for (int h = 630; h <= 640; h++) begin
            add(1, 1, h, h == 630, R6, h == 630,
                (h < 636) ? bit_of(R5, h - 630) : 3'b000, 0);
        end
        add(1, 0, 641, 0, RZ, 0, 3'b000, 0);
        for (int h = 0; h <= 12; h++) begin
            add(1, 1, h, 0, RZ, 1,
                (h < 12) ? bit_of(R6, h) : 3'b000, h == 12);
        end
        add(1, 0, 13, 0, RZ, 1, 3'b000, 0);
        run("clip");

        // pix_en every 4th clk, handshake on a non-tick cycle
        pix_en = 1'b0;
        bright = 1'b0;
        drive_row(1'b1, R7);
        #1;
        chk("slow_push_rdy", 32'(rif.row_ready), 32'd1);
        @(posedge clk);
        #1;
        drive_row(1'b0, RZ);
        for (int k = 0; k < 12; k++) begin
            for (int c = 0; c < 4; c++) begin
                pix_en = (c == 0);
                bright = 1'b1;
                hcount = 11'(k);
                if (k == 5 && c == 2) begin
                    drive_row(1'b1, R8);
                    #1;
                    chk("slow_mid_rdy", 32'(rif.row_ready), 32'd1);
                end
                @(posedge clk);
                #1;
                drive_row(1'b0, RZ);
                chk($sformatf("slow_k%0d_c%0d", k, c),
                    32'({red, green, blue}), 32'(bit_of(R7, k)));
            end
        end
        pix_en = 1'b1;
        hcount = 11'd12;
        @(posedge clk);
        #1;
        chk("slow_load_rgb", 32'({red, green, blue}), 32'(bit_of(R8, 0)));
        chk("slow_load_und", 32'(underrun), 32'd0);

        // reset at pixel 5 of a glyph with a row waiting in the buffer
        for (int j = 1; j <= 5; j++) begin
            hcount = 11'(12 + j);
            rst_n = (j != 5);
            if (j == 2) begin
                drive_row(1'b1, R9);
                #1;
                chk("mrst_push_rdy", 32'(rif.row_ready), 32'd1);
            end
            @(posedge clk);
            #1;
            drive_row(1'b0, RZ);
            chk($sformatf("mrst_px%0d", j), 32'({red, green, blue}),
                32'((j == 5) ? 3'b000 : bit_of(R8, j)));
            chk($sformatf("mrst_und%0d", j), 32'(underrun), 32'd0);
        end
        rst_n = 1'b1;
        bright = 1'b0;
        #1;
        chk("mrst_rdy", 32'(rif.row_ready), 32'd1);
        @(posedge clk);
        #1;
        bright = 1'b1;
        hcount = 11'd0;
        @(posedge clk);
        #1;
        chk("mrst_new_rgb", 32'({red, green, blue}), 32'd0);
        chk("mrst_new_und", 32'(underrun), 32'd1);
        bright = 1'b0;
        @(posedge clk);
        #1;

`ifdef GLYPH_UNDERRUN_STATS_EN
        for (int i = 0; i < 70000; i++) begin
            bright = 1'b1;
            @(posedge clk);
            bright = 1'b0;
            @(posedge clk);
        end
        #1;
        chk("cnt_sat", 32'(underrun_cnt), 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
